// File: rtl/bp_fe_bp_ghist_spec_if.sv
// Request/prediction/update bundle for the global-history direction predictor.
// The master side issues requests and resolved updates; the slave side is the predictor.
interface bp_fe_bp_ghist_spec_if #(
    parameter int bht_idx_width_p = 10,
    parameter int bp_n_hist_p     = 6,
    parameter int stat_width_p    = 16
);
    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] r_pc_idx_i;
    logic                       predict_v_o;
    logic                       predict_o;
    logic [bp_n_hist_p-1:0]     predict_ghist_o;
    logic                       w_v_i;
    logic [bht_idx_width_p-1:0] w_pc_idx_i;
    logic [bp_n_hist_p-1:0]     w_ghist_i;
    logic                       w_taken_i;
    logic                       w_mispredict_i;
    logic [stat_width_p-1:0]    mispredict_cnt_o;

    modport master (
        output r_v_i, r_pc_idx_i, w_v_i, w_pc_idx_i, w_ghist_i, w_taken_i, w_mispredict_i,
        input  predict_v_o, predict_o, predict_ghist_o, mispredict_cnt_o
    );

    modport slave (
        input  r_v_i, r_pc_idx_i, w_v_i, w_pc_idx_i, w_ghist_i, w_taken_i, w_mispredict_i,
        output predict_v_o, predict_o, predict_ghist_o, mispredict_cnt_o
    );
endinterface

// File: rtl/bp_fe_bp_ghist_spec.sv
// Global-history direction predictor (gselect/gshare) with speculative history,
// mispredict history repair, a registered read-modify-write update stage and a mispredict counter.
module bp_fe_bp_ghist_spec #(
    parameter int bht_idx_width_p   = 10,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int bp_n_hist_p       = 6,
    parameter int hash_mode_p       = 0,
    parameter int stat_width_p      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fe_bp_ghist_spec_if.slave  bp_if
);
    localparam int w_lp       = bht_idx_width_p;
    localparam int b_lp       = bp_cnt_sat_bits_p;
    localparam int h_lp       = bp_n_hist_p;
    localparam int s_lp       = stat_width_p;
    localparam int bht_els_lp = 1 << w_lp;

    localparam logic [b_lp-1:0] cnt_init_lp = b_lp'((1 << (b_lp - 1)) - 1);
    localparam logic [b_lp-1:0] cnt_max_lp  = {b_lp{1'b1}};
    localparam logic [b_lp-1:0] cnt_min_lp  = {b_lp{1'b0}};
    localparam logic [s_lp-1:0] stat_max_lp = {s_lp{1'b1}};

    // gselect drops the upper PC bits to make room for history; gshare folds history into the low bits
    function automatic logic [w_lp-1:0] hash_idx(input logic [w_lp-1:0] pc, input logic [h_lp-1:0] gh);
        logic [w_lp-1:0] idx;
        if (hash_mode_p == 0) begin
            idx = (pc << h_lp) | w_lp'(gh);
        end else begin
            idx = pc ^ w_lp'(gh);
        end
        return idx;
    endfunction

    function automatic logic [b_lp-1:0] sat_next(input logic [b_lp-1:0] cnt, input logic taken);
        logic [b_lp-1:0] nxt;
        if (taken) begin
            if (cnt == cnt_max_lp) nxt = cnt;
            else                   nxt = cnt + b_lp'(1'b1);
        end else begin
            if (cnt == cnt_min_lp) nxt = cnt;
            else                   nxt = cnt - b_lp'(1'b1);
        end
        return nxt;
    endfunction

    logic [b_lp-1:0] bht_r [bht_els_lp];
    logic [h_lp-1:0] spec_gh_r;
    logic            upd_v_r;
    logic [w_lp-1:0] upd_idx_r;
    logic            upd_taken_r;
    logic            predict_v_r;
    logic            predict_r;
    logic [h_lp-1:0] predict_ghist_r;
    logic [s_lp-1:0] mispredict_cnt_r;

    logic [w_lp-1:0] pred_idx_s;
    logic            pred_dir_s;
    logic            squash_s;
    logic            pred_fire_s;
    logic [h_lp-1:0] spec_gh_next_s;
    logic [b_lp-1:0] upd_cnt_next_s;

    // Prediction lookup, history next-state and update-stage counter arithmetic
    always_comb begin
        pred_idx_s     = hash_idx(bp_if.r_pc_idx_i, spec_gh_r);
        pred_dir_s     = bht_r[pred_idx_s][b_lp-1];
        squash_s       = bp_if.w_v_i & bp_if.w_mispredict_i;
        pred_fire_s    = bp_if.r_v_i & ~squash_s;
        spec_gh_next_s = spec_gh_r;
        if (squash_s) begin
            spec_gh_next_s = h_lp'({bp_if.w_ghist_i, bp_if.w_taken_i});
        end else if (bp_if.r_v_i) begin
            spec_gh_next_s = h_lp'({spec_gh_r, pred_dir_s});
        end else begin
            spec_gh_next_s = spec_gh_r;
        end
        upd_cnt_next_s = sat_next(bht_r[upd_idx_r], upd_taken_r);
    end

    // Counter table: reset to weakly not-taken, written one cycle after an update is captured
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < bht_els_lp; i++) begin
                bht_r[i] <= cnt_init_lp;
            end
        end else if (upd_v_r) begin
            bht_r[upd_idx_r] <= upd_cnt_next_s;
        end
    end

    // Update capture stage; a reset drops whatever is pending
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            upd_v_r     <= 1'b0;
            upd_idx_r   <= {w_lp{1'b0}};
            upd_taken_r <= 1'b0;
        end else begin
            upd_v_r <= bp_if.w_v_i;
            if (bp_if.w_v_i) begin
                upd_idx_r   <= hash_idx(bp_if.w_pc_idx_i, bp_if.w_ghist_i);
                upd_taken_r <= bp_if.w_taken_i;
            end
        end
    end

    // Speculative history, registered prediction outputs and mispredict statistics
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            spec_gh_r        <= {h_lp{1'b0}};
            predict_v_r      <= 1'b0;
            predict_r        <= 1'b0;
            predict_ghist_r  <= {h_lp{1'b0}};
            mispredict_cnt_r <= {s_lp{1'b0}};
        end else begin
            spec_gh_r   <= spec_gh_next_s;
            predict_v_r <= pred_fire_s;
            if (pred_fire_s) begin
                predict_r       <= pred_dir_s;
                predict_ghist_r <= spec_gh_r;
            end
            if (squash_s && (mispredict_cnt_r != stat_max_lp)) begin
                mispredict_cnt_r <= mispredict_cnt_r + s_lp'(1'b1);
            end
        end
    end

    assign bp_if.predict_v_o      = predict_v_r;
    assign bp_if.predict_o        = predict_r;
    assign bp_if.predict_ghist_o  = predict_ghist_r;
    assign bp_if.mispredict_cnt_o = mispredict_cnt_r;

endmodule

// File: tb/tb_bp_fe_bp_ghist_spec.sv
// Bench: a gselect and a gshare instance driven with identical stimulus, scored against a
// table-of-counters reference model through prediction queues drained by a monitor.
module tb_bp_fe_bp_ghist_spec;
    localparam int W = 4;
    localparam int B = 2;
    localparam int H = 2;
    localparam int S = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bp_fe_bp_ghist_spec_if #(.bht_idx_width_p(W), .bp_n_hist_p(H), .stat_width_p(S)) if0 ();
    bp_fe_bp_ghist_spec_if #(.bht_idx_width_p(W), .bp_n_hist_p(H), .stat_width_p(S)) if1 ();

    bp_fe_bp_ghist_spec #(.bht_idx_width_p(W), .bp_cnt_sat_bits_p(B), .bp_n_hist_p(H),
                          .hash_mode_p(0), .stat_width_p(S))
        u_gsel (.clk_i(clk), .reset_n_i(reset_n), .bp_if(if0));

    bp_fe_bp_ghist_spec #(.bht_idx_width_p(W), .bp_cnt_sat_bits_p(B), .bp_n_hist_p(H),
                          .hash_mode_p(1), .stat_width_p(S))
        u_gshr (.clk_i(clk), .reset_n_i(reset_n), .bp_if(if1));

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct packed { int due; logic [15:0] val; } cnt_exp_t;
    cnt_exp_t   cq[$];
    logic [2:0] pq0[$];
    logic [2:0] pq1[$];

    // reference model state: [0] = gselect, [1] = gshare
    int mb[2][16];
    int mg[2];
    int pv[2];
    int pidx[2];
    int pt[2];
    int mcnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int mhash(input int m, input int pc, input int gh);
        if (m == 0) return (pc * 4 + gh) % 16;
        else        return pc ^ gh;
    endfunction

    task automatic model_step(input int rv, input int rpc, input int wv, input int wpc,
                              input int wgh, input int wt, input int wm, input int rstn);
        int sq;
        if (rstn == 0) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 16; i++) mb[m][i] = 1;
                mg[m] = 0;
                pv[m] = 0;
            end
            mcnt = 0;
        end else begin
            sq = (wv != 0 && wm != 0) ? 1 : 0;
            for (int m = 0; m < 2; m++) begin
                int dir;
                dir = 0;
                if (rv != 0 && sq == 0) begin
                    dir = (mb[m][mhash(m, rpc, mg[m])] >= 2) ? 1 : 0;
                    if (m == 0) pq0.push_back(3'(dir * 4 + mg[m]));
                    else        pq1.push_back(3'(dir * 4 + mg[m]));
                end
                if (sq != 0)      mg[m] = (wgh * 2 + wt) % 4;
                else if (rv != 0) mg[m] = (mg[m] * 2 + dir) % 4;
                if (pv[m] != 0) begin
                    if (pt[m] != 0) mb[m][pidx[m]] = (mb[m][pidx[m]] == 3) ? 3 : mb[m][pidx[m]] + 1;
                    else            mb[m][pidx[m]] = (mb[m][pidx[m]] == 0) ? 0 : mb[m][pidx[m]] - 1;
                end
                pv[m]   = wv;
                pidx[m] = mhash(m, wpc, wgh);
                pt[m]   = wt;
            end
            if (sq != 0 && mcnt < 65535) mcnt++;
        end
        cq.push_back('{due: cyc + 1, val: 16'(mcnt)});
    endtask

    task automatic step(input int rv, input int rpc, input int wv, input int wpc,
                        input int wgh, input int wt, input int wm, input int rstn);
        reset_n            = (rstn != 0);
        if0.r_v_i          = (rv != 0);
        if0.r_pc_idx_i     = 4'(rpc);
        if0.w_v_i          = (wv != 0);
        if0.w_pc_idx_i     = 4'(wpc);
        if0.w_ghist_i      = 2'(wgh);
        if0.w_taken_i      = (wt != 0);
        if0.w_mispredict_i = (wm != 0);
        if1.r_v_i          = (rv != 0);
        if1.r_pc_idx_i     = 4'(rpc);
        if1.w_v_i          = (wv != 0);
        if1.w_pc_idx_i     = 4'(wpc);
        if1.w_ghist_i      = 2'(wgh);
        if1.w_taken_i      = (wt != 0);
        if1.w_mispredict_i = (wm != 0);
        model_step(rv, rpc, wv, wpc, wgh, wt, wm, rstn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                                     step(0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic rst();                                      step(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rd(input int pc);                           step(1, pc, 0, 0, 0, 0, 0, 1); endtask
    task automatic upd(input int pc, input int gh, input int t); step(0, 0, 1, pc, gh, t, 0, 1); endtask

    // Monitor: pops an expected prediction whenever an instance presents one
    always @(negedge clk) begin
        logic [2:0] e;
        cnt_exp_t   ce;
        if (if0.predict_v_o === 1'b1) begin
            if (pq0.size() == 0) chk("gsel_unexpected_valid", 1, 0);
            else begin
                e = pq0.pop_front();
                chk("gsel_predict", int'(if0.predict_o), int'(e[2]));
                chk("gsel_ghist", int'(if0.predict_ghist_o), int'(e[1:0]));
            end
        end
        if (if1.predict_v_o === 1'b1) begin
            if (pq1.size() == 0) chk("gshr_unexpected_valid", 1, 0);
            else begin
                e = pq1.pop_front();
                chk("gshr_predict", int'(if1.predict_o), int'(e[2]));
                chk("gshr_ghist", int'(if1.predict_ghist_o), int'(e[1:0]));
            end
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
            ce = cq.pop_front();
            chk("gsel_mispredict_cnt", int'(if0.mispredict_cnt_o), int'(ce.val));
            chk("gshr_mispredict_cnt", int'(if1.mispredict_cnt_o), int'(ce.val));
        end
    end

    initial begin
        @(posedge clk);
        #1;
        rst();
        rst();
        chk("rst_gsel_v",    int'(if0.predict_v_o), 0);
        chk("rst_gsel_p",    int'(if0.predict_o), 0);
        chk("rst_gsel_gh",   int'(if0.predict_ghist_o), 0);
        chk("rst_gsel_cnt",  int'(if0.mispredict_cnt_o), 0);
        chk("rst_gshr_v",    int'(if1.predict_v_o), 0);
        chk("rst_gshr_cnt",  int'(if1.mispredict_cnt_o), 0);

        // first prediction after reset: weakly not-taken, history stays 00
        rd(0);
        chk("s1_v",  int'(if0.predict_v_o), 1);
        chk("s1_p",  int'(if0.predict_o), 0);
        chk("s1_gh", int'(if0.predict_ghist_o), 0);
        rd(0);
        chk("s1_gh_after", int'(if0.predict_ghist_o), 0);

        // two back-to-back taken updates to idx 1100, read two cycles later
        upd(3, 0, 1);
        upd(3, 0, 1);
        idle();
        rd(3);
        chk("s2_p",  int'(if0.predict_o), 1);
        chk("s2_gh", int'(if0.predict_ghist_o), 0);

        // mispredict concurrent with a read: history repaired to 01, read squashed
        step(1, 0, 1, 0, 2, 1, 1, 1);
        chk("s4_squash_v", int'(if0.predict_v_o), 0);
        chk("s4_cnt",      int'(if0.mispredict_cnt_o), 1);
        rd(0);
        chk("s4_gh_repaired", int'(if0.predict_ghist_o), 1);

        // saturation at both ends for idx 0000
        rst();
        for (int i = 0; i < 6; i++) upd(0, 0, 1);
        idle();
        rd(0);
        chk("s3_sat_hi", int'(if0.predict_o), 1);
        step(0, 0, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) upd(0, 0, 0);
        idle();
        rd(0);
        chk("s3_sat_lo", int'(if0.predict_o), 0);
        chk("s3_sat_lo_gh", int'(if0.predict_ghist_o), 0);

        // gshare: pc 0101 ^ gh 11 = 0110
        rst();
        for (int i = 0; i < 3; i++) upd(5, 3, 1);
        step(0, 0, 1, 0, 1, 1, 1, 1);
        rd(5);
        chk("s5_gshr_p",  int'(if1.predict_o), 1);
        chk("s5_gshr_gh", int'(if1.predict_ghist_o), 3);

        // a reset in the cycle after capture drops the pending update
        rst();
        upd(3, 0, 1);
        rst();
        rd(3);
        chk("s6_p",   int'(if0.predict_o), 0);
        chk("s6_cnt", int'(if0.mispredict_cnt_o), 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            int wv;
            wv = int'($urandom_range(0, 1));
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 wv, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 99) == 0) ? 0 : 1);
        end
        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("gsel_queue_drained", pq0.size(), 0);
        chk("gshr_queue_drained", pq1.size(), 0);
        chk("cnt_queue_drained",  cq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
